// File: rtl/mem_stage.sv
// Memory pipeline stage: registers execute results, collects late SRAM load data,
// extracts byte/half/word loads. Optional MEM_LOAD_TIMEOUT_EN adds a bounded load wait.
module mem_stage #(
  parameter int PC_W           = 32,
  parameter int DATA_W         = 32,
  parameter int RF_AW          = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        stall,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [2:0]        ex_mem_op,
  input  logic              ex_rf_we,
  input  logic [RF_AW-1:0]  ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              data_sram_rvalid,
  output logic              stallreq_for_mem,
  output logic [PC_W-1:0]   wb_pc,
  output logic              wb_rf_we,
  output logic [RF_AW-1:0]  wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              fwd_we,
  output logic [RF_AW-1:0]  fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_load_pending,
  output logic              load_timeout,
  output logic [1:0]        dbg_state
);

  // Handshake: data_sram_rvalid is a one-cycle pulse carrying data_sram_rdata; there is
  // no ready, the stage must accept it in S_WAIT. stall[3]=1 holds this stage.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HAVE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LB   = 3'b001;
  localparam logic [2:0] OP_LBU  = 3'b010;
  localparam logic [2:0] OP_LH   = 3'b011;
  localparam logic [2:0] OP_LHU  = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;

  function automatic logic is_load(input logic [2:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  logic [PC_W-1:0]   r_pc;
  logic [2:0]        r_op;
  logic              r_we;
  logic [RF_AW-1:0]  r_waddr;
  logic [DATA_W-1:0] r_result;
  state_t            state;
  logic [DATA_W-1:0] buf_q;

  logic [2:0]        ex_op_n;
  logic              capture;
  logic              bubble;
  logic              load_present;
  logic              timeout_now;
  logic              resp_any;
  logic [DATA_W-1:0] resp_data;
  logic [DATA_W-1:0] load_src;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_val;
  logic              unused_ok;

  assign unused_ok = ^{stall[5], stall[2:0], 1'(TIMEOUT_CYCLES)};

  assign ex_op_n      = is_load(ex_mem_op) ? ex_mem_op : OP_NONE;
  assign capture      = !stall[3];
  assign bubble       = stall[3] && !stall[4];
  assign load_present = is_load(r_op);

  // Response is only meaningful while waiting; in S_IDLE/S_HAVE rvalid is ignored.
  assign resp_any  = (state == S_WAIT) && (data_sram_rvalid || timeout_now);
  assign resp_data = data_sram_rvalid ? data_sram_rdata : '0;
  assign load_src  = (state == S_HAVE) ? buf_q : resp_data;

  assign stallreq_for_mem = load_present && (state != S_HAVE) && !data_sram_rvalid && !timeout_now;
  assign fwd_load_pending = stallreq_for_mem;

  always_comb begin
    ld_byte = load_src[7:0];
    case (r_result[1:0])
      2'd0:    ld_byte = load_src[7:0];
      2'd1:    ld_byte = load_src[15:8];
      2'd2:    ld_byte = load_src[23:16];
      default: ld_byte = load_src[31:24];
    endcase
    ld_half = r_result[1] ? load_src[31:16] : load_src[15:0];
  end

  always_comb begin
    load_val = '0;
    case (r_op)
      OP_LB:   load_val = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      OP_LBU:  load_val = {{(DATA_W-8){1'b0}}, ld_byte};
      OP_LH:   load_val = {{(DATA_W-16){ld_half[15]}}, ld_half};
      OP_LHU:  load_val = {{(DATA_W-16){1'b0}}, ld_half};
      OP_LW:   load_val = load_src;
      default: load_val = '0;
    endcase
  end

  assign wb_pc       = r_pc;
  assign wb_rf_waddr = r_waddr;
  assign wb_rf_we    = r_we && !stallreq_for_mem;
  assign wb_rf_wdata = load_present ? load_val : r_result;
  assign fwd_we      = wb_rf_we;
  assign fwd_waddr   = wb_rf_waddr;
  assign fwd_wdata   = wb_rf_wdata;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc     <= '0;
      r_op     <= OP_NONE;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_result <= '0;
    end else if (bubble) begin
      r_pc     <= '0;
      r_op     <= OP_NONE;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_result <= '0;
    end else if (capture) begin
      r_pc     <= ex_pc;
      r_op     <= ex_op_n;
      r_we     <= ex_rf_we;
      r_waddr  <= ex_rf_waddr;
      r_result <= ex_result;
    end
  end

  // A held stage that receives its response (or times out) parks the data in buf_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      buf_q <= '0;
    end else if (bubble) begin
      state <= S_IDLE;
    end else if (capture) begin
      state <= is_load(ex_op_n) ? S_WAIT : S_IDLE;
    end else if (state == S_WAIT && resp_any) begin
      state <= S_HAVE;
      buf_q <= resp_data;
    end
  end

`ifdef MEM_LOAD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign timeout_now  = (state == S_WAIT) && !data_sram_rvalid &&
                        (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign load_timeout = timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (timeout_now) timeout_q <= 1'b1;
      if (state != S_WAIT || capture || bubble || resp_any) wait_cnt <= '0;
      else wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_now  = 1'b0;
  assign load_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: pass-through, load lanes, late and
// buffered responses, bubble insertion and reset during a pending load.
module tb_mem_stage;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int RF_AW  = 5;
  localparam int TO     = 4;
  localparam logic [5:0] HOLD   = 6'b011000;
  localparam logic [5:0] BUBBLE = 6'b001000;

  logic              clk;
  logic              resetn;
  logic [5:0]        stall;
  logic [PC_W-1:0]   ex_pc;
  logic [2:0]        ex_mem_op;
  logic              ex_rf_we;
  logic [RF_AW-1:0]  ex_rf_waddr;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              data_sram_rvalid;
  logic              stallreq_for_mem;
  logic [PC_W-1:0]   wb_pc;
  logic              wb_rf_we;
  logic [RF_AW-1:0]  wb_rf_waddr;
  logic [DATA_W-1:0] wb_rf_wdata;
  logic              fwd_we;
  logic [RF_AW-1:0]  fwd_waddr;
  logic [DATA_W-1:0] fwd_wdata;
  logic              fwd_load_pending;
  logic              load_timeout;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage #(
    .PC_W(PC_W), .DATA_W(DATA_W), .RF_AW(RF_AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .ex_pc(ex_pc), .ex_mem_op(ex_mem_op), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .data_sram_rdata(data_sram_rdata), .data_sram_rvalid(data_sram_rvalid),
    .stallreq_for_mem(stallreq_for_mem), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .fwd_load_pending(fwd_load_pending), .load_timeout(load_timeout),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Drivers
  task automatic drive_ex(input logic [2:0] op, input logic we, input logic [RF_AW-1:0] wa,
                          input logic [DATA_W-1:0] res, input logic [PC_W-1:0] pc);
    ex_mem_op   = op;
    ex_rf_we    = we;
    ex_rf_waddr = wa;
    ex_result   = res;
    ex_pc       = pc;
  endtask

  task automatic drive_idle();
    drive_ex(3'b000, 1'b0, '0, '0, '0);
  endtask

  // Place one instruction into the stage register (inputs set at negedge, captured at posedge).
  task automatic issue(input logic [2:0] op, input logic we, input logic [RF_AW-1:0] wa,
                       input logic [DATA_W-1:0] res, input logic [PC_W-1:0] pc);
    @(negedge clk);
    drive_ex(op, we, wa, res, pc);
    stall = 6'b0;
    data_sram_rvalid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    stall = 6'b0;
    data_sram_rvalid = 1'b0;
    data_sram_rdata = '0;
    drive_idle();
    @(negedge clk); #1;
    n_checks++; if (wb_pc !== '0) $display("FAIL reset_pc: got %h expected 0", wb_pc); else n_pass++;
    n_checks++; if (wb_rf_we !== 1'b0) $display("FAIL reset_we: got %b expected 0", wb_rf_we); else n_pass++;
    n_checks++; if (wb_rf_wdata !== '0) $display("FAIL reset_wdata: got %h expected 0", wb_rf_wdata); else n_pass++;
    n_checks++; if (stallreq_for_mem !== 1'b0) $display("FAIL reset_stallreq: got %b expected 0", stallreq_for_mem); else n_pass++;
    n_checks++; if (load_timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", load_timeout); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_passthrough();
    issue(3'b000, 1'b1, 5'd8, 32'h1234_5678, 32'h0000_0100);
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++; if (wb_rf_wdata !== 32'h1234_5678) $display("FAIL pass_wdata: got %h expected 12345678", wb_rf_wdata); else n_pass++;
    n_checks++; if (wb_rf_we !== 1'b1) $display("FAIL pass_we: got %b expected 1", wb_rf_we); else n_pass++;
    n_checks++; if (wb_rf_waddr !== 5'd8) $display("FAIL pass_waddr: got %0d expected 8", wb_rf_waddr); else n_pass++;
    n_checks++; if (wb_pc !== 32'h100) $display("FAIL pass_pc: got %h expected 100", wb_pc); else n_pass++;
    n_checks++; if (stallreq_for_mem !== 1'b0) $display("FAIL pass_stallreq: got %b expected 0", stallreq_for_mem); else n_pass++;
    n_checks++; if (fwd_we !== 1'b1 || fwd_wdata !== 32'h1234_5678 || fwd_waddr !== 5'd8)
      $display("FAIL pass_fwd: got we=%b a=%0d d=%h expected we=1 a=8 d=12345678", fwd_we, fwd_waddr, fwd_wdata);
    else n_pass++;
  endtask

  task automatic test_load_lanes();
    logic [2:0]  ops [5];
    logic [1:0]  lo  [5];
    logic [31:0] exp [5];
    ops = '{3'b001, 3'b010, 3'b001, 3'b011, 3'b100};
    lo  = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0};
    exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], 1'b1, 5'd3, {30'h0000_0400, lo[i]}, 32'h200 + 32'(i));
      @(negedge clk);
      drive_idle();
      data_sram_rdata  = 32'h80FF_7F01;
      data_sram_rvalid = 1'b1;
      #1;
      n_checks++; if (wb_rf_wdata !== exp[i]) $display("FAIL lane_%0d_wdata: got %h expected %h", i, wb_rf_wdata, exp[i]); else n_pass++;
      n_checks++; if (wb_rf_we !== 1'b1 || stallreq_for_mem !== 1'b0)
        $display("FAIL lane_%0d_ctl: got we=%b stallreq=%b expected we=1 stallreq=0", i, wb_rf_we, stallreq_for_mem);
      else n_pass++;
    end
    @(negedge clk);
    data_sram_rvalid = 1'b0;
  endtask

  task automatic test_late_response();
    int stall_cycles;
    stall_cycles = 0;
    issue(3'b101, 1'b1, 5'd9, 32'h0000_2000, 32'h300);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle();
      stall = HOLD;
      data_sram_rvalid = 1'b0;
      #1;
      if (stallreq_for_mem === 1'b1) stall_cycles++;
      n_checks++; if (wb_rf_we !== 1'b0 || fwd_we !== 1'b0) $display("FAIL late_we_%0d: got we=%b fwd=%b expected 0", i, wb_rf_we, fwd_we); else n_pass++;
      n_checks++; if (fwd_load_pending !== 1'b1) $display("FAIL late_pending_%0d: got %b expected 1", i, fwd_load_pending); else n_pass++;
    end
    n_checks++; if (stall_cycles != 3) $display("FAIL late_stall_count: got %0d expected 3", stall_cycles); else n_pass++;
    @(negedge clk);
    stall = 6'b0;
    data_sram_rdata  = 32'hDEAD_BEEF;
    data_sram_rvalid = 1'b1;
    #1;
    n_checks++; if (stallreq_for_mem !== 1'b0) $display("FAIL late_release: got %b expected 0", stallreq_for_mem); else n_pass++;
    n_checks++; if (wb_rf_we !== 1'b1 || wb_rf_wdata !== 32'hDEAD_BEEF || wb_rf_waddr !== 5'd9)
      $display("FAIL late_data: got we=%b d=%h a=%0d expected we=1 d=deadbeef a=9", wb_rf_we, wb_rf_wdata, wb_rf_waddr);
    else n_pass++;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    #1;
    n_checks++; if (wb_rf_we !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL late_retire: got we=%b state=%0d expected we=0 state=0", wb_rf_we, dbg_state);
    else n_pass++;
  endtask

  task automatic test_buffered_response();
    issue(3'b101, 1'b1, 5'd10, 32'h0000_3000, 32'h400);
    @(negedge clk);
    drive_idle();
    stall = HOLD;
    data_sram_rdata  = 32'hCAFE_F00D;
    data_sram_rvalid = 1'b1;
    #1;
    n_checks++; if (stallreq_for_mem !== 1'b0 || wb_rf_wdata !== 32'hCAFE_F00D)
      $display("FAIL have_first: got stallreq=%b d=%h expected 0 cafef00d", stallreq_for_mem, wb_rf_wdata);
    else n_pass++;
    @(negedge clk);
    data_sram_rdata  = 32'h1111_1111;
    data_sram_rvalid = 1'b1;
    #1;
    n_checks++; if (dbg_state !== 2'd2) $display("FAIL have_state: got %0d expected 2", dbg_state); else n_pass++;
    n_checks++; if (stallreq_for_mem !== 1'b0 || wb_rf_wdata !== 32'hCAFE_F00D)
      $display("FAIL have_ignore_rvalid: got stallreq=%b d=%h expected 0 cafef00d", stallreq_for_mem, wb_rf_wdata);
    else n_pass++;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    stall = 6'b0;
    #1;
    n_checks++; if (wb_rf_we !== 1'b1 || wb_rf_wdata !== 32'hCAFE_F00D || dbg_state !== 2'd2)
      $display("FAIL have_release: got we=%b d=%h state=%0d expected 1 cafef00d 2", wb_rf_we, wb_rf_wdata, dbg_state);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (wb_rf_we !== 1'b0 || wb_rf_wdata !== '0 || dbg_state !== 2'd0)
      $display("FAIL have_once: got we=%b d=%h state=%0d expected 0 0 0", wb_rf_we, wb_rf_wdata, dbg_state);
    else n_pass++;
  endtask

  task automatic test_bubble();
    issue(3'b000, 1'b1, 5'd5, 32'h0000_0055, 32'h500);
    @(negedge clk);
    drive_ex(3'b000, 1'b1, 5'd6, 32'h66, 32'h600);
    stall = BUBBLE;
    #1;
    n_checks++; if (wb_pc !== 32'h500 || wb_rf_wdata !== 32'h55)
      $display("FAIL bubble_before: got pc=%h d=%h expected 500 55", wb_pc, wb_rf_wdata);
    else n_pass++;
    @(negedge clk);
    stall = 6'b0;
    drive_idle();
    #1;
    n_checks++; if (wb_rf_we !== 1'b0 || wb_pc !== '0 || wb_rf_waddr !== '0)
      $display("FAIL bubble_after: got we=%b pc=%h a=%0d expected 0 0 0", wb_rf_we, wb_pc, wb_rf_waddr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    issue(3'b101, 1'b1, 5'd7, 32'h0000_7000, 32'h700);
    @(negedge clk);
    drive_idle();
    stall = HOLD;
    #1;
    n_checks++; if (stallreq_for_mem !== 1'b1) $display("FAIL midrst_wait: got %b expected 1", stallreq_for_mem); else n_pass++;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++; if (stallreq_for_mem !== 1'b0 || wb_pc !== '0 || wb_rf_waddr !== '0 || dbg_state !== 2'd0)
      $display("FAIL midrst_clear: got stallreq=%b pc=%h a=%0d state=%0d expected all 0", stallreq_for_mem, wb_pc, wb_rf_waddr, dbg_state);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    stall = 6'b0;
    data_sram_rdata  = 32'hABCD_1234;
    data_sram_rvalid = 1'b1;
    #1;
    n_checks++; if (wb_rf_we !== 1'b0 || wb_rf_wdata !== '0 || stallreq_for_mem !== 1'b0)
      $display("FAIL midrst_rvalid: got we=%b d=%h stallreq=%b expected 0 0 0", wb_rf_we, wb_rf_wdata, stallreq_for_mem);
    else n_pass++;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
    #1;
    n_checks++; if (wb_rf_we !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL midrst_after: got we=%b state=%0d expected 0 0", wb_rf_we, dbg_state);
    else n_pass++;
  endtask

`ifdef MEM_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    int stall_cycles;
    stall_cycles = 0;
    issue(3'b101, 1'b1, 5'd11, 32'h0000_8000, 32'h800);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      drive_idle();
      stall = HOLD;
      #1;
      if (stallreq_for_mem === 1'b1) stall_cycles++;
    end
    n_checks++; if (stall_cycles != TO) $display("FAIL to_stall_count: got %0d expected %0d", stall_cycles, TO); else n_pass++;
    @(negedge clk);
    stall = 6'b0;
    #1;
    n_checks++; if (stallreq_for_mem !== 1'b0 || wb_rf_we !== 1'b1 || wb_rf_wdata !== '0)
      $display("FAIL to_complete: got stallreq=%b we=%b d=%h expected 0 1 0", stallreq_for_mem, wb_rf_we, wb_rf_wdata);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (load_timeout !== 1'b1 || dbg_state !== 2'd0)
      $display("FAIL to_flag: got flag=%b state=%0d expected 1 0", load_timeout, dbg_state);
    else n_pass++;
  endtask
`else
  task automatic test_timeout();
    issue(3'b101, 1'b1, 5'd11, 32'h0000_8000, 32'h800);
    for (int i = 0; i < TO + 3; i++) begin
      @(negedge clk);
      drive_idle();
      stall = HOLD;
    end
    #1;
    n_checks++; if (stallreq_for_mem !== 1'b1 || load_timeout !== 1'b0)
      $display("FAIL no_timeout: got stallreq=%b flag=%b expected 1 0", stallreq_for_mem, load_timeout);
    else n_pass++;
    @(negedge clk);
    stall = 6'b0;
    data_sram_rdata  = 32'h0BAD_CAFE;
    data_sram_rvalid = 1'b1;
    #1;
    n_checks++; if (wb_rf_we !== 1'b1 || wb_rf_wdata !== 32'h0BAD_CAFE)
      $display("FAIL no_timeout_data: got we=%b d=%h expected 1 0badcafe", wb_rf_we, wb_rf_wdata);
    else n_pass++;
    @(negedge clk);
    data_sram_rvalid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load_lanes();
    test_late_response();
    test_buffered_response();
    test_bubble();
    test_reset_mid_load();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers the execute-to-memory fields and collects the data-SRAM read response for loads, which may arrive one or more cycles late.
- Performs byte/half/word load extraction with sign or zero extension.
- Produces the write-back fields and a forwarding bus; requests a pipeline stall while a load response is outstanding.

Parameters:
- PC_W, 32, width of stage PC.
- DATA_W, 32, datapath width (fixed 32 for load lane logic).
- RF_AW, 5, register-file address width.
- TIMEOUT_CYCLES, 255, wait limit used only with MEM_LOAD_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- stall  in  6  stall vector; bit 3 = this stage, bit 4 = write-back stage; 1 = Stop.
- ex_pc  in  PC_W  PC of the instruction leaving execute.
- ex_mem_op  in  3  000 none/store, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw; 110/111 treated as 000.
- ex_rf_we  in  1  register write enable.
- ex_rf_waddr  in  RF_AW  destination register.
- ex_result  in  DATA_W  ALU result / memory address.
- data_sram_rdata  in  DATA_W  read data.
- data_sram_rvalid  in  1  read data valid, single-cycle pulse per load.
- stallreq_for_mem  out  1  1 while a load in this stage has no data.
- wb_pc  out  PC_W  PC to write-back.
- wb_rf_we  out  1  write enable to write-back.
- wb_rf_waddr  out  RF_AW  destination to write-back.
- wb_rf_wdata  out  DATA_W  result to write-back.
- fwd_we, fwd_waddr, fwd_wdata  out  1/RF_AW/DATA_W  forwarding copy of wb_rf_* fields.
- fwd_load_pending  out  1  load in stage, data not yet available.
- load_timeout  out  1  sticky timeout flag; only with MEM_LOAD_TIMEOUT_EN, else tied 0.

Behaviour:
- Async reset (resetn=0): stage register, FSM, data buffer and all outputs go to 0; state S_IDLE.
- Stage register update at posedge clk:
  - stall[3]=1 and stall[4]=0: load a bubble (all zero).
  - Else if stall[3]=0: capture the ex_* fields.
  - Else hold.
- Load present: registered mem_op is in 001..101.
- FSM states:
  - S_IDLE: no load pending.
  - S_WAIT: load present, no response yet.
  - S_HAVE: response buffered, stage still held.
- FSM transitions:
  - A load captured into the stage register enters S_WAIT, unless rvalid is high in its first MEM cycle. In that case rdata is used combinationally that cycle, with zero-cycle added latency.
  - S_WAIT + rvalid + stall[3]=0: retire and return to S_IDLE, or to S_WAIT if the next instruction is also a load.
  - S_WAIT + rvalid + stall[3]=1: buffer rdata and go to S_HAVE.
  - S_HAVE: use the buffer; leave when stall[3]=0.
  - rvalid in S_IDLE or S_HAVE is ignored.
- stallreq_for_mem = load present and state ≠ S_HAVE and rvalid=0. It is combinational from rvalid.
- fwd_load_pending = stallreq_for_mem.
- While stallreq_for_mem=1: wb_rf_we=0 and fwd_we=0, so the write-back stage sees a bubble.
- Load data source: rvalid ? data_sram_rdata : buffer. Lane select uses the registered ex_result[1:0].
  - lb/lbu: byte at bit offset 8*addr[1:0]; sign-extend bit 7, or zero-extend.
  - lh/lhu: halfword at offset 16*addr[1]; addr[0] ignored; sign-extend bit 15, or zero-extend.
  - lw: full word; addr[1:0] ignored.
- Non-load: wb_rf_wdata = registered ex_result.
- wb_pc and wb_rf_waddr always reflect the stage register.
- Reset mid-load: the pending load is dropped; a subsequent rvalid is ignored (S_IDLE).

Optional Feature:
- Macro MEM_LOAD_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter increments in S_WAIT and clears on leaving S_WAIT.
  - When the count reaches TIMEOUT_CYCLES without rvalid, the load completes with data 0 and wb_rf_we=1.
  - load_timeout is set, cleared only by reset, and the FSM returns to S_IDLE.
- Not defined: no counter; the stage waits indefinitely; load_timeout = 0.

Test Plan:
- Non-load pass-through: ex_result=0x1234_5678, rf_we=1, waddr=8, no stalls → next cycle wb_rf_wdata=0x12345678, wb_rf_we=1, wb_rf_waddr=8, stallreq=0.
- lb/lbu lanes: rdata=0x80FF_7F01 returned in the first cycle.
  - lb addr…3 → 0xFFFFFF80.
  - lbu addr…3 → 0x00000080.
  - lb addr…1 → 0x0000007F.
  - lh addr…2 → 0xFFFF80FF.
  - lhu addr…0 → 0x00007F01.
- Late response: lw enters, rvalid 3 cycles later with 0xDEADBEEF → stallreq=1 for exactly 3 cycles, wb_rf_we=0 meanwhile, then wb_rf_wdata=0xDEADBEEF in the rvalid cycle.
- Response under downstream stall: rvalid=1 with 0xCAFEF00D while stall[3]=1 for 2 cycles → S_HAVE, stallreq=0, buffer holds; after release, writes 0xCAFEF00D once, and an extra rvalid in S_HAVE is ignored.
- Bubble insertion: stall[3]=1, stall[4]=0 → next cycle wb_rf_we=0, wb_pc=0.
- Reset during S_WAIT: resetn low for 1 cycle, then rvalid pulse → all outputs 0, no write issued; with MEM_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4, no rvalid → completes after 4 cycles with data 0 and load_timeout=1.
